// File: rtl/sipo_deserializer_if.sv
// Serial stream in, word holding register out, for sipo_deserializer.
// master = serial source plus word consumer; slave = the deserializer.
interface sipo_deserializer_if #(
  parameter int SIZE = 8
);
  logic            serial_in;
  logic            serial_valid;
  logic            data_ready;
  logic [SIZE-1:0] data_out;
  logic            data_valid;
  logic            busy;
  logic            overrun;
  logic            parity_err;

  modport master (
    output serial_in, serial_valid, data_ready,
    input  data_out, data_valid, busy, overrun, parity_err
  );

  modport slave (
    input  serial_in, serial_valid, data_ready,
    output data_out, data_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Reassembles SIZE-bit words from a 1-bit stream into a valid/ready holding register, flagging overruns.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and report parity_err.
module sipo_deserializer #(
  parameter int SIZE      = 8,
  parameter int SHIFT_DIR = 0
) (
  input logic                clk,
  input logic                reset_n,
  sipo_deserializer_if.slave bus
);
`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = SIZE + 1;
`else
  localparam int FRAME_LEN = SIZE;
`endif
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [SIZE-1:0] r_sr;
  logic [CW-1:0]   r_bit_count;
  logic [SIZE-1:0] r_data_out;
  logic            r_data_valid;
  logic            r_busy;
  logic            r_overrun;
  logic            r_parity_err;

  logic [SIZE-1:0] w_word;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_last;
  logic            w_par;
  int              w_pos;

  // w_word is the shift register with the current bit merged in, so the
  // completing edge can deliver a word that includes its own sample.
  always_comb begin
    w_word = r_sr;
    w_pos  = (SHIFT_DIR != 0) ? (SIZE - 1 - int'(r_bit_count)) : int'(r_bit_count);
    if (int'(r_bit_count) < SIZE) begin
      for (int i = 0; i < SIZE; i++) begin
        if (i == w_pos) w_word[i] = bus.serial_in;
      end
    end
  end

  assign w_last    = bus.serial_valid && (r_bit_count == LAST);
  assign w_cnt_nxt = w_last ? '0 : r_bit_count + 1'b1;

`ifdef SIPO_PARITY_EN
  assign w_par = (^r_sr) ^ bus.serial_in;
`else
  assign w_par = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr         <= '0;
      r_bit_count  <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (bus.serial_valid) begin
        r_sr        <= w_word;
        r_bit_count <= w_cnt_nxt;
      end
      r_busy    <= bus.serial_valid ? (w_cnt_nxt != '0) : (r_bit_count != '0);
      r_overrun <= w_last && r_data_valid && !bus.data_ready;
      // A completion may reuse the slot in the same edge it is being consumed.
      if (w_last && (!r_data_valid || bus.data_ready)) begin
        r_data_out   <= w_word;
        r_data_valid <= 1'b1;
        r_parity_err <= w_par;
      end else if (r_data_valid && bus.data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;
  assign bus.parity_err = r_parity_err;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one LSB-first and one MSB-first instance fed in lockstep,
// words scoreboarded on consumption plus directed checks of busy/overrun/reset behaviour.
module tb_sipo_deserializer;
  localparam int SIZE = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL  = SIZE + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = SIZE;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic s_in0, s_in1, s_vld, d_rdy;

  sipo_deserializer_if #(.SIZE(SIZE)) bus0 ();
  sipo_deserializer_if #(.SIZE(SIZE)) bus1 ();

  assign bus0.serial_in    = s_in0;
  assign bus0.serial_valid = s_vld;
  assign bus0.data_ready   = d_rdy;
  assign bus1.serial_in    = s_in1;
  assign bus1.serial_valid = s_vld;
  assign bus1.data_ready   = d_rdy;

  sipo_deserializer #(.SIZE(SIZE), .SHIFT_DIR(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  sipo_deserializer #(.SIZE(SIZE), .SHIFT_DIR(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int busy_cyc = 0;
  int ovr_cnt  = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words are checked when consumed: valid&ready seen here means the next edge takes data_out.
  always @(negedge clk) begin
    logic [8:0] e;
    if (bus0.busy) busy_cyc++;
    if (bus0.overrun) ovr_cnt++;
    if (reset_n && bus0.data_valid && d_rdy) begin
      chk("q0_nonempty", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("dut0_word", 32'({bus0.parity_err, bus0.data_out}), 32'(e));
      end
    end
    if (reset_n && bus1.data_valid && d_rdy) begin
      chk("q1_nonempty", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("dut1_word", 32'({bus1.parity_err, bus1.data_out}), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic expect_word(input logic [7:0] e0, input logic [7:0] e1, input bit flip);
    q0.push_back({PAR & flip, e0});
    q1.push_back({PAR & flip, e1});
  endtask

  // b0[i]/b1[i] is the i-th bit sent to dut0/dut1; gap idle cycles follow each non-final bit.
  task automatic send_bits(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                           input bit flip, input bit rdy_last);
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1 && rdy_last) d_rdy = 1'b1;
      if (i == FL - 1 && gap > 0) begin
        chk("pause_no_early0", 32'(bus0.data_valid), 0);
        chk("pause_no_early1", 32'(bus1.data_valid), 0);
      end
      if (i < SIZE) begin
        s_in0 = b0[i];
        s_in1 = b1[i];
      end else begin
        s_in0 = (^b0) ^ flip;
        s_in1 = (^b1) ^ flip;
      end
      s_vld = 1'b1;
      cyc();
      s_vld = 1'b0;
      if (i < FL - 1) repeat (gap) cyc();
    end
  endtask

  initial begin
    int snap;
    s_in0   = 1'b0;
    s_in1   = 1'b0;
    s_vld   = 1'b0;
    d_rdy   = 1'b1;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_data_out", 32'(bus0.data_out), 0);
    chk("rst_data_valid", 32'(bus0.data_valid), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_overrun", 32'(bus0.overrun), 0);
    chk("rst_parity_err", 32'(bus0.parity_err), 0);
    chk("rst_data_valid1", 32'(bus1.data_valid), 0);
    reset_n = 1'b1;
    cyc();

    // Stream 1,0,1,1,0,0,1,0 to both: LSB-first gives 4D, MSB-first gives B2.
    expect_word(8'h4D, 8'hB2, 1'b0);
    snap = busy_cyc;
    send_bits(8'h4D, 8'h4D, 0, 1'b0, 1'b0);
    chk("stream_busy_cycles", 32'(busy_cyc - snap), 32'(FL - 1));
    chk("stream_valid", 32'(bus0.data_valid), 1);
    chk("stream_lsb", 32'(bus0.data_out), 32'h4D);
    chk("stream_msb", 32'(bus1.data_out), 32'hB2);
    chk("stream_busy_after", 32'(bus0.busy), 0);

    // PISO-ordered loopback, then back-to-back frames at full rate.
    expect_word(8'hA5, 8'hA5, 1'b0);
    send_bits(8'hA5, rev8(8'hA5), 0, 1'b0, 1'b0);
    expect_word(8'h96, 8'h96, 1'b0);
    send_bits(8'h96, rev8(8'h96), 0, 1'b0, 1'b0);
    expect_word(8'h0F, 8'h0F, 1'b0);
    send_bits(8'h0F, rev8(8'h0F), 0, 1'b0, 1'b0);
    chk("b2b_lsb", 32'(bus0.data_out), 32'h0F);
    chk("b2b_msb", 32'(bus1.data_out), 32'h0F);

    // Gapped stream: two idle cycles between bits.
    expect_word(8'hFF, 8'hFF, 1'b0);
    send_bits(8'hFF, 8'hFF, 2, 1'b0, 1'b0);
    chk("pause_word", 32'(bus0.data_out), 32'hFF);

    // Overrun: 11 held, 22 dropped, then 33 completes on the consuming edge.
    cyc();
    cyc();
    d_rdy = 1'b0;
    expect_word(8'h11, 8'h11, 1'b0);
    send_bits(8'h11, rev8(8'h11), 0, 1'b0, 1'b0);
    snap = ovr_cnt;
    send_bits(8'h22, rev8(8'h22), 0, 1'b0, 1'b0);
    chk("ovr_pulse0", 32'(bus0.overrun), 1);
    chk("ovr_pulse1", 32'(bus1.overrun), 1);
    chk("ovr_hold0", 32'(bus0.data_out), 32'h11);
    chk("ovr_hold1", 32'(bus1.data_out), 32'h11);
    cyc();
    chk("ovr_clear", 32'(bus0.overrun), 0);
    cyc();
    chk("ovr_count", 32'(ovr_cnt - snap), 1);
    expect_word(8'h33, 8'h33, 1'b0);
    send_bits(8'h33, rev8(8'h33), 0, 1'b0, 1'b1);
    chk("swap_word0", 32'(bus0.data_out), 32'h33);
    chk("swap_word1", 32'(bus1.data_out), 32'h33);
    chk("swap_valid", 32'(bus0.data_valid), 1);
    chk("swap_no_ovr", 32'(bus0.overrun), 0);
    cyc();
    chk("swap_ovr_count", 32'(ovr_cnt - snap), 1);

    // Reset after three bits of a frame discards it.
    s_in0 = 1'b1;
    s_in1 = 1'b1;
    s_vld = 1'b1;
    repeat (3) cyc();
    s_vld = 1'b0;
    chk("mid_busy", 32'(bus0.busy), 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mid_rst_busy", 32'(bus0.busy), 0);
    chk("mid_rst_valid", 32'(bus0.data_valid), 0);
    chk("mid_rst_data", 32'(bus0.data_out), 0);
    expect_word(8'h3C, 8'h3C, 1'b0);
    send_bits(8'h3C, rev8(8'h3C), 0, 1'b0, 1'b0);
    chk("post_rst_word0", 32'(bus0.data_out), 32'h3C);
    chk("post_rst_word1", 32'(bus1.data_out), 32'h3C);
    chk("par_ok", 32'(bus0.parity_err), 0);
    expect_word(8'h3C, 8'h3C, 1'b1);
    send_bits(8'h3C, rev8(8'h3C), 0, 1'b1, 1'b0);
    chk("par_bad", 32'(bus0.parity_err), 32'(PAR));

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) cyc();
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-to-parallel receiver that reassembles SIZE-bit words from a one-bit-per-cycle stream. It sits directly downstream of the PISO serializer and consumes its `out`/`busy` pair. It presents each completed word in a holding register with a valid/ready handshake and flags overruns. It must use the same SIZE and SHIFT_DIR as the PISO it pairs with, so that words round-trip bit-exact.

## Interface
- SIZE, 8: word width in bits; legal for SIZE >= 1.
- SHIFT_DIR, 0: 0 = the first received bit lands in data_out[0] (LSB first); 1 = the first received bit lands in data_out[SIZE-1] (MSB first).
- clk  input  1  clock; every state change happens on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled on each edge where this is high.
- data_out  output  SIZE  holding register with the last completed word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out on an edge where data_valid and data_ready are both high.
- busy  output  1  a frame is partially received (bit_count != 0).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  parity result for the word in data_out; tied 0 when parity is compiled out.

## Operation
- Internal state:
  - shift register sr[SIZE-1:0].
  - bit_count, width max(1, $clog2(FRAME_LEN)), where FRAME_LEN = SIZE, or SIZE+1 with parity enabled.
- Sampling: on an edge with serial_valid=1, serial_in is written to sr[bit_count] (SHIFT_DIR=0) or to sr[SIZE-1-bit_count] (SHIFT_DIR=1), and bit_count increments.
- Pause: with serial_valid=0, bit_count and sr hold. Gaps of any length between bits are legal.
- Frame completion: the sample taken at bit_count = FRAME_LEN-1 completes the frame, and bit_count wraps to 0 on that edge.
- Delivery: the completed word includes the bit sampled on the completing edge.
  - If the holding register is free (data_valid=0), or is being consumed on the same edge (data_ready=1), the word loads into data_out and data_valid=1.
  - Otherwise the word is dropped, data_out and data_valid are unchanged, and overrun pulses high for one cycle.
- Consumption: data_valid=1 and data_ready=1 with no simultaneous completion clears data_valid. data_out keeps its stale value.
- Simultaneous completion and consumption: the new word replaces the old one, data_valid stays 1, and there is no overrun.
- busy = (bit_count != 0), registered.
- Reset (reset_n=0 at an edge), including mid-frame:
  - data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, bit_count=0, sr=0.
  - A partial frame is discarded, and the next valid bit is bit 0 of a new frame.

## Timing
- Latency: the last bit is sampled at edge N, and data_valid/data_out/parity_err are visible after edge N.
- overrun asserts after the completing edge N and deasserts after edge N+1.
- Back-to-back frames at full rate (serial_valid held high) are sustained with no dead cycles when data_ready is held high.
- data_ready may toggle freely. It is only meaningful while data_valid=1.
- No combinational path exists from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame is SIZE data bits followed by one even-parity bit, so FRAME_LEN = SIZE+1.
  - The parity bit is not stored in data_out.
  - parity_err = XOR(data bits, parity bit), loaded together with data_out.
  - A word with a parity error is still delivered.
- SIPO_PARITY_EN undefined: FRAME_LEN = SIZE and parity_err is constant 0.

## Test plan
- SIZE=8, SHIFT_DIR=0, data_ready=1, serial stream 1,0,1,1,0,0,1,0 on consecutive cycles -> data_out=8'h4D, data_valid high after the 8th edge, busy high for 7 cycles.
- SHIFT_DIR=1 with the same stream -> data_out=8'hB2.
- Loopback PISO->sipo_deserializer with input 8'hA5 in both SHIFT_DIR settings -> data_out=8'hA5.
- Pause case: serial_valid toggles 1,0,0,1,... across 8 valid bits 0xFF -> single word 8'hFF, with no early completion.
- Overrun case: data_ready=0, send 8'h11 then 8'h22 -> data_out stays 8'h11, overrun pulses exactly once after the 16th valid edge.
  - Then raise data_ready together with a 3rd frame completion (8'h33) -> data_out=8'h33, data_valid remains 1, no overrun.
- Reset_n low for one edge after 3 bits of a frame, then send 8'h3C -> data_out=8'h3C.
  - With SIPO_PARITY_EN: 8'h3C plus parity 0 -> parity_err=0; plus parity 1 -> parity_err=1.
